// File: rtl/cpu_fpu_div.sv
// cpu_fpu_div: binary32 divider, round-to-nearest-even.
// i_request/i_op1/i_op2 in; o_ready/o_result out.
module cpu_fpu_div (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_ready,
  output logic [31:0] o_result
);

  typedef enum logic [3:0] {
    IDLE, SPECIAL_CASES, NORMALIZE_A, NORMALIZE_B,
    DIVIDE_0, DIVIDE_1, DIVIDE_2, DIVIDE_3,
    NORMALIZE_1, NORMALIZE_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] E_MIN = -10'sd126;
  localparam logic signed [9:0] E_MAX = 10'sd127;
  localparam logic signed [9:0] E_ZD  = -10'sd127;
  localparam logic signed [9:0] E_INF = 10'sd128;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t r_state, w_next;

  logic               r_a_s, r_b_s, r_z_s;
  logic signed [9:0]  r_a_e, r_b_e, r_z_e;
  logic [23:0]        r_a_m, r_b_m, r_z_m;
  logic               r_guard, r_round, r_sticky;
  logic [26:0]        r_quot;
  logic [24:0]        r_rem;
  logic [73:0]        r_dvd;
  logic [23:0]        r_dvs;
  logic [5:0]         r_count;
  logic [31:0]        r_z;
  logic               r_ready;

  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic        w_a_zero, w_b_zero, w_special, w_z_s;
  logic [31:0] w_spec_z;
  logic        w_under, w_flush;
  logic [7:0]  w_bexp;

  assign w_z_s    = r_a_s ^ r_b_s;
  assign w_a_nan  = (r_a_e == E_INF) && (r_a_m[22:0] != 23'd0);
  assign w_b_nan  = (r_b_e == E_INF) && (r_b_m[22:0] != 23'd0);
  assign w_a_inf  = (r_a_e == E_INF) && (r_a_m[22:0] == 23'd0);
  assign w_b_inf  = (r_b_e == E_INF) && (r_b_m[22:0] == 23'd0);
  assign w_a_zero = (r_a_e == E_ZD) && (r_a_m[22:0] == 23'd0);
  assign w_b_zero = (r_b_e == E_ZD) && (r_b_m[22:0] == 23'd0);
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf
                   | w_a_zero | w_b_zero;

  // Deep underflow: once every bit has shifted out, further
  // shifts only feed sticky, so jump straight to E_MIN.
  assign w_under = r_z_e < E_MIN;
  assign w_flush = (r_z_m == 24'd0) && !r_guard;
  assign w_bexp  = r_z_e[7:0] + 8'd127;

  assign o_ready  = r_ready;
  assign o_result = r_z;

  always_comb begin
    w_spec_z = 32'd0;
    if (w_a_nan || w_b_nan)
      w_spec_z = QNAN;
    else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero))
      w_spec_z = QNAN;
    else if (w_a_inf)
      w_spec_z = {w_z_s, 8'hFF, 23'd0};
    else if (w_b_inf)
      w_spec_z = {w_z_s, 31'd0};
    else if (w_b_zero)
      w_spec_z = {w_z_s, 8'hFF, 23'd0};
    else if (w_a_zero)
      w_spec_z = {w_z_s, 31'd0};
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:          if (i_request) w_next = SPECIAL_CASES;
      SPECIAL_CASES: w_next = w_special ? PUT_Z : NORMALIZE_A;
      NORMALIZE_A:   if (r_a_m[23]) w_next = NORMALIZE_B;
      NORMALIZE_B:   if (r_b_m[23]) w_next = DIVIDE_0;
      DIVIDE_0:      w_next = DIVIDE_1;
      DIVIDE_1:      w_next = DIVIDE_2;
      DIVIDE_2:
        w_next = (r_count == 6'd49) ? DIVIDE_3 : DIVIDE_1;
      DIVIDE_3:      w_next = NORMALIZE_1;
      NORMALIZE_1:   if (r_z_m[23]) w_next = NORMALIZE_2;
      NORMALIZE_2:
        if (!w_under || w_flush) w_next = ROUND;
      ROUND:         w_next = PACK;
      PACK:          w_next = PUT_Z;
      PUT_Z:         if (!i_request) w_next = IDLE;
      default:       w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_a_s <= 1'b0; r_b_s <= 1'b0; r_z_s <= 1'b0;
      r_a_e <= '0; r_b_e <= '0; r_z_e <= '0;
      r_a_m <= '0; r_b_m <= '0; r_z_m <= '0;
      r_guard <= 1'b0; r_round <= 1'b0; r_sticky <= 1'b0;
      r_quot <= '0; r_rem <= '0; r_dvd <= '0; r_dvs <= '0;
      r_count <= '0; r_z <= '0; r_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (i_request) begin
            r_a_s <= i_op1[31];
            r_b_s <= i_op2[31];
            r_a_e <= $signed({2'b00, i_op1[30:23]}) - 10'sd127;
            r_b_e <= $signed({2'b00, i_op2[30:23]}) - 10'sd127;
            r_a_m <= {1'b0, i_op1[22:0]};
            r_b_m <= {1'b0, i_op2[22:0]};
          end
        end
        SPECIAL_CASES: begin
          if (w_special) begin
            r_z     <= w_spec_z;
            r_ready <= 1'b1;
          end else begin
            if (r_a_e == E_ZD) r_a_e <= E_MIN;
            else               r_a_m[23] <= 1'b1;
            if (r_b_e == E_ZD) r_b_e <= E_MIN;
            else               r_b_m[23] <= 1'b1;
          end
        end
        NORMALIZE_A:
          if (!r_a_m[23]) begin
            r_a_m <= r_a_m << 1;
            r_a_e <= r_a_e - 10'sd1;
          end
        NORMALIZE_B:
          if (!r_b_m[23]) begin
            r_b_m <= r_b_m << 1;
            r_b_e <= r_b_e - 10'sd1;
          end
        DIVIDE_0: begin
          r_z_s   <= w_z_s;
          r_z_e   <= r_a_e - r_b_e;
          r_quot  <= '0;
          r_rem   <= '0;
          r_dvd   <= {r_a_m, 50'd0};
          r_dvs   <= r_b_m;
          r_count <= '0;
        end
        DIVIDE_1: begin
          r_quot <= r_quot << 1;
          r_rem  <= {r_rem[23:0], r_dvd[73]};
          r_dvd  <= r_dvd << 1;
        end
        DIVIDE_2: begin
          if (r_rem >= {1'b0, r_dvs}) begin
            r_rem     <= r_rem - {1'b0, r_dvs};
            r_quot[0] <= 1'b1;
          end
          r_count <= r_count + 6'd1;
        end
        DIVIDE_3: begin
          r_z_m    <= r_quot[26:3];
          r_guard  <= r_quot[2];
          r_round  <= r_quot[1];
          r_sticky <= r_quot[0] | (r_rem != 25'd0);
        end
        NORMALIZE_1:
          if (!r_z_m[23]) begin
            r_z_m   <= {r_z_m[22:0], r_guard};
            r_guard <= r_round;
            r_round <= 1'b0;
            r_z_e   <= r_z_e - 10'sd1;
          end
        NORMALIZE_2:
          if (w_under) begin
            if (w_flush) begin
              r_z_e    <= E_MIN;
              r_round  <= 1'b0;
              r_sticky <= r_sticky | r_round;
            end else begin
              r_z_m    <= r_z_m >> 1;
              r_z_e    <= r_z_e + 10'sd1;
              r_guard  <= r_z_m[0];
              r_round  <= r_guard;
              r_sticky <= r_sticky | r_round;
            end
          end
        ROUND:
          if (r_guard && (r_round || r_sticky || r_z_m[0])) begin
            r_z_m <= r_z_m + 24'd1;
            if (r_z_m == 24'hFFFFFF) r_z_e <= r_z_e + 10'sd1;
          end
        PACK: begin
          r_ready <= 1'b1;
          if (r_z_e > E_MAX)
            r_z <= {r_z_s, 8'hFF, 23'd0};
          else if ((r_z_e == E_MIN) && !r_z_m[23])
            r_z <= {r_z_s, 8'd0, r_z_m[22:0]};
          else
            r_z <= {r_z_s, w_bexp, r_z_m[22:0]};
        end
        PUT_Z:
          if (!i_request) r_ready <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
